// File: rtl/bcd_scan_display_pkg.sv
// Shared constants for the multiplexed 8-digit BCD display.
// Segment glyphs are active-low: bit 0 = a ... bit 6 = g.
package bcd_scan_display_pkg;

    localparam int unsigned NUM_DIGITS = 8;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/bcd_scan_display_if.sv
// Data/strobe bundle between a bin2bcd producer and the scanning display.
interface bcd_scan_display_if;

    logic       load;
    logic [3:0] num0;
    logic [3:0] num1;
    logic [3:0] num2;
    logic [3:0] num3;
    logic [3:0] num4;
    logic [3:0] num5;
    logic [3:0] num6;
    logic [3:0] num7;
    logic       lz_en;
    logic       ovf;
    logic [6:0] seg;
    logic [7:0] an;

    modport master (
        output load, num0, num1, num2, num3, num4, num5, num6, num7, lz_en, ovf,
        input  seg, an
    );

    modport slave (
        input  load, num0, num1, num2, num3, num4, num5, num6, num7, lz_en, ovf,
        output seg, an
    );

endinterface

// File: rtl/seg7_decode.sv
// BCD nibble to active-low 7-segment glyph; codes 10-15 show a dash.
module seg7_decode
    import bcd_scan_display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed 8-digit BCD display with shadow registers, leading-zero
// blanking and overflow blink; seg/an are registered.
module bcd_scan_display
    import bcd_scan_display_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 50000,
    parameter int unsigned BLINK_TICKS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    bcd_scan_display_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam int unsigned BLK_W = $clog2(BLINK_TICKS + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [BLK_W-1:0] r_bcnt;
    logic             r_phase;
    logic [3:0]       r_dig [NUM_DIGITS];
    logic             r_lz;
    logic             r_ovf;
    logic [6:0]       r_seg;
    logic [7:0]       r_an;

    logic [3:0]       w_in [NUM_DIGITS];
    logic             w_tick;
    logic [2:0]       w_msd;
    logic             w_blank;
    logic [6:0]       w_glyph;

    always_comb begin
        w_in[0] = bus.num0;
        w_in[1] = bus.num1;
        w_in[2] = bus.num2;
        w_in[3] = bus.num3;
        w_in[4] = bus.num4;
        w_in[5] = bus.num5;
        w_in[6] = bus.num6;
        w_in[7] = bus.num7;
    end

    assign w_tick = (r_cnt == CNT_W'(CLK_DIV - 1));

    // All-zero data yields MSD 0, so digit 0 is never blanked.
    always_comb begin
        w_msd = 3'd0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (r_dig[i] != 4'd0) w_msd = 3'(i);
        end
    end

    assign w_blank = r_lz && (r_idx > w_msd);

    seg7_decode u_decode (
        .i_bcd (r_dig[r_idx]),
        .o_seg (w_glyph)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_bcnt  <= '0;
            r_phase <= 1'b0;
            r_lz    <= 1'b0;
            r_ovf   <= 1'b0;
            r_seg   <= SEG_OFF;
            r_an    <= 8'hFF;
            for (int i = 0; i < NUM_DIGITS; i++) r_dig[i] <= 4'd0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
            if (w_tick) r_idx <= r_idx + 3'd1;

            if ((bus.load && !bus.ovf) || !r_ovf) begin
                r_bcnt  <= '0;
                r_phase <= 1'b0;
            end else if (w_tick) begin
                if (r_bcnt == BLK_W'(BLINK_TICKS - 1)) begin
                    r_bcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_bcnt <= r_bcnt + BLK_W'(1);
                end
            end

            if (bus.load) begin
                r_lz  <= bus.lz_en;
                r_ovf <= bus.ovf;
                for (int i = 0; i < NUM_DIGITS; i++) r_dig[i] <= w_in[i];
            end

            if ((r_ovf && r_phase) || w_blank) begin
                r_an  <= 8'hFF;
                r_seg <= SEG_OFF;
            end else begin
                r_an  <= ~(8'd1 << r_idx);
                r_seg <= w_glyph;
            end
        end
    end

    assign bus.seg = r_seg;
    assign bus.an  = r_an;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomised bench for bcd_scan_display against a cycle-count based model.
module tb_bcd_scan_display;

    localparam int unsigned CLK_DIV     = 4;
    localparam int unsigned BLINK_TICKS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_scan_display_if bus ();

    bcd_scan_display #(
        .CLK_DIV     (CLK_DIV),
        .BLINK_TICKS (BLINK_TICKS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Active-high gfedcba patterns for 0..9.
    logic [6:0] glyph_on [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int         m_k;
    int         m_oticks;
    logic [3:0] m_d [8];
    logic       m_lz;
    logic       m_ovf;
    int         m_idx;
    int         m_msd;
    logic       m_tick;
    logic       exp_valid = 1'b0;
    logic       exp_seg_chk;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        if (d < 4'd10) return ~glyph_on[d];
        return ~7'h40;
    endfunction

    // Model: index and blink phase derive from elapsed cycle/tick counts.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            exp_an = 8'hFF; exp_seg = 7'h7F; exp_seg_chk = 1'b1;
            m_k = 0; m_oticks = 0; m_lz = 1'b0; m_ovf = 1'b0;
            for (int i = 0; i < 8; i++) m_d[i] = 4'd0;
        end else begin
            m_idx = (m_k / CLK_DIV) % 8;
            m_msd = 0;
            for (int i = 0; i < 8; i++) if (m_d[i] != 4'd0) m_msd = i;
            exp_seg_chk = 1'b1;
            if (m_ovf && ((m_oticks / BLINK_TICKS) % 2) == 1) begin
                exp_an = 8'hFF; exp_seg_chk = 1'b0;
            end else if (m_lz && m_idx > m_msd) begin
                exp_an = 8'hFF; exp_seg = 7'h7F;
            end else begin
                exp_an  = ~(8'd1 << m_idx);
                exp_seg = seg_of(m_d[m_idx]);
            end
            m_tick = ((m_k % CLK_DIV) == CLK_DIV - 1);
            if ((bus.load && !bus.ovf) || !m_ovf) m_oticks = 0;
            else if (m_tick) m_oticks++;
            if (bus.load) begin
                m_lz = bus.lz_en; m_ovf = bus.ovf;
                m_d[0] = bus.num0; m_d[1] = bus.num1; m_d[2] = bus.num2; m_d[3] = bus.num3;
                m_d[4] = bus.num4; m_d[5] = bus.num5; m_d[6] = bus.num6; m_d[7] = bus.num7;
            end
            m_k++;
        end
        exp_valid = 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (exp_valid) begin
            chk("model_an", bus.an, exp_an);
            if (exp_seg_chk) chk("model_seg", {1'b0, bus.seg}, {1'b0, exp_seg});
        end
    end

    task automatic set_nums(input logic [31:0] v);
        bus.num0 = v[3:0];   bus.num1 = v[7:4];   bus.num2 = v[11:8];  bus.num3 = v[15:12];
        bus.num4 = v[19:16]; bus.num5 = v[23:20]; bus.num6 = v[27:24]; bus.num7 = v[31:28];
    endtask

    task automatic do_load(input logic [31:0] v, input logic lz, input logic ov);
        @(negedge clk);
        set_nums(v); bus.lz_en = lz; bus.ovf = ov; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        set_nums($urandom); bus.lz_en = 1'($urandom); bus.ovf = 1'($urandom);
    endtask

    int   seen;
    int   n_off;
    int   n_on;
    logic found;
    logic [31:0] rv;

    initial begin
        bus.load = 1'b0; bus.lz_en = 1'b0; bus.ovf = 1'b0;
        set_nums(32'h13572468);
        repeat (3) @(negedge clk);
        chk("rst_an", bus.an, 8'hFF);
        chk("rst_seg", {1'b0, bus.seg}, 8'h7F);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_an", bus.an, 8'hFE);
        chk("post_rst_seg", {1'b0, bus.seg}, 8'h40);

        do_load(32'h87654321, 1'b0, 1'b0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.an == 8'h7F) begin seen++; chk("s030_d7", {1'b0, bus.seg}, 8'h00); end
            if (bus.an == 8'hFE) chk("s030_d0", {1'b0, bus.seg}, 8'h79);
        end
        chk("s030_seen_d7", 8'(seen > 0), 8'd1);

        do_load(32'h00000042, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.an == 8'hFE) chk("s031_d0", {1'b0, bus.seg}, 8'h24);
            else if (bus.an == 8'hFD) chk("s031_d1", {1'b0, bus.seg}, 8'h19);
            else chk("s031_blank", bus.an, 8'hFF);
        end

        do_load(32'h00000000, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.an == 8'hFE) chk("s032_d0", {1'b0, bus.seg}, 8'h40);
            else chk("s032_blank", bus.an, 8'hFF);
        end

        do_load(32'h8765C321, 1'b0, 1'b0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.an == 8'hF7) begin seen++; chk("s033_dash", {1'b0, bus.seg}, 8'h3F); end
        end
        chk("s033_seen_d3", 8'(seen > 0), 8'd1);

        do_load(32'h87654321, 1'b0, 1'b1);
        n_off = 0; n_on = 0;
        for (int i = 0; i < 96; i++) begin
            @(negedge clk);
            if (bus.an == 8'hFF) n_off++; else n_on++;
        end
        chk("s034_blink_off", 8'(n_off >= 40 && n_off <= 56), 8'd1);
        chk("s034_blink_on", 8'(n_on >= 40), 8'd1);
        do_load(32'h87654321, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("s034_steady", 8'(bus.an == 8'hFF), 8'd0);
        end

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom % 200) == 0;
            bus.load = ($urandom % 8) == 0;
            rv = $urandom;
            for (int d = 0; d < 8; d++) if (d > int'($urandom % 8)) rv[4*d +: 4] = 4'd0;
            set_nums(rv);
            bus.lz_en = 1'($urandom);
            bus.ovf = ($urandom % 3) == 0;
        end
        @(negedge clk);
        rst = 1'b0; bus.load = 1'b0;

        do_load(32'h87654321, 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if ((m_k / CLK_DIV) % 8 == 5 && (m_k % CLK_DIV) == 1) found = 1'b1;
        end
        chk("s035_reach_idx5", 8'(found), 8'd1);
        rst = 1'b1; bus.load = 1'b1; set_nums(32'h99999999); bus.lz_en = 1'b1; bus.ovf = 1'b1;
        @(negedge clk);
        chk("s035_rst_an", bus.an, 8'hFF);
        chk("s035_rst_seg", {1'b0, bus.seg}, 8'h7F);
        rst = 1'b0; bus.load = 1'b0;
        @(negedge clk);
        chk("s035_idx0_an", bus.an, 8'hFE);
        chk("s035_no_load_seg", {1'b0, bus.seg}, 8'h40);
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 Parameter CLK_DIV, default 50000, meaning clk cycles per digit-scan tick (range 2..2^20).
REQ-002 Parameter BLINK_TICKS, default 1024, meaning scan ticks per blink half-period (range 1..2^16).
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port load  input  1  one-cycle strobe; captures num0..num7, lz_en, ovf.
REQ-006 Port num0..num7  input  4 each  BCD digits from bin2bcd; num0 is the least significant digit, num7 the most significant.
REQ-007 Port lz_en  input  1  leading-zero blanking enable.
REQ-008 Port ovf  input  1  overflow/error indication; causes blinking.
REQ-009 Port seg  output  7  active-low segments; seg[0]=a ... seg[6]=g.
REQ-010 Port an  output  8  active-low digit enables; an[i] drives digit i.

Function
REQ-011 On load=1, the block SHALL latch num0..num7, lz_en and ovf into shadow registers; the display SHALL use the shadow values from the next cycle onward.
REQ-012 While load=0, input changes SHALL NOT affect outputs.
REQ-013 Prescaler SHALL count 0..CLK_DIV-1 and wrap; tick SHALL be asserted for one cycle when the count equals CLK_DIV-1.
REQ-014 Scan index SHALL be 3 bits, SHALL advance on each tick, and SHALL wrap from 7 to 0.
REQ-015 seg/an SHALL be registered and SHALL reflect the current scan index and shadow data with 1-cycle latency; exactly one an bit SHALL be 0 unless the digit is blanked.
REQ-016 Decode: 0-9 SHALL map to the standard 7-seg glyphs (0=a..f, 1=b,c, 7=a,b,c, etc.); 10-15 SHALL display '-' (g only).
REQ-017 Leading-zero blanking: with lz_en=1, digit i SHALL be blanked (an[i]=1, seg=7'h7F) when i > MSD, where MSD is the highest index with a nonzero digit; digit 0 SHALL never be blanked.
REQ-018 With lz_en=0, all 8 digits SHALL be displayed.
REQ-019 Blink: while shadow ovf=1, a counter SHALL toggle a phase every BLINK_TICKS ticks; in the off phase an SHALL be 8'hFF.
REQ-020 The blink counter and phase SHALL clear whenever shadow ovf=0, and on the cycle after a load with ovf=0.
REQ-021 A load coinciding with a tick SHALL apply both: the index advances, and the new data is used from the next cycle.
REQ-022 A load SHALL NOT reset the prescaler or the scan index.

Reset
REQ-023 While rst=1, the block SHALL drive an=8'hFF and seg=7'h7F.
REQ-024 While rst=1, the prescaler, scan index, blink counter and blink phase SHALL be 0, and the shadow digits, lz_en and ovf SHALL be 0.
REQ-025 rst SHALL override load and tick on the same edge.
REQ-026 After rst is released, the first tick SHALL occur CLK_DIV cycles later; until then digit 0 SHALL show '0' from the first post-reset cycle.

Structure
REQ-027 A shared package SHALL hold the segment glyph constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF) and the digit count constant 8.
REQ-028 A combinational sub-module seg7_decode (4-bit in, 7-bit active-low out) SHALL perform the glyph lookup.
REQ-029 MSD detection SHALL be combinational on the shadow digits.

Verification (CLK_DIV=4, BLINK_TICKS=2)
REQ-030 Scenario: reset, then load digits 1,2,3,4,5,6,7,8 (num0..num7) with lz_en=0 -> an cycles FE,FD,...,7F every 4 clk; seg shows 8 at an=7F and 1 at an=FE.
REQ-031 Scenario: load 00000042 (num1=4, num0=2) with lz_en=1 -> only an=FE (glyph 2) and an=FD (glyph 4) are ever active; the other 6 slots show an=FF.
REQ-032 Scenario: load all zeros with lz_en=1 -> digit 0 shows glyph 0; digits 1-7 are blanked.
REQ-033 Scenario: num3=4'hC -> the digit 3 slot shows '-' (seg=7'h3F).
REQ-034 Scenario: ovf=1 -> the display alternates 2 ticks on / 2 ticks off (an=FF); a subsequent load with ovf=0 -> steady display from the next cycle.
REQ-035 Scenario: assert rst mid-scan at index 5 -> the next edge gives an=FF, seg=7F, index 0; load asserted during rst is ignored.
